// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS_R2000 unified memory port arbiter.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } arb_state_e;

    typedef logic gnt_id_t;

    localparam gnt_id_t    GNT_IF  = 1'b0;
    localparam gnt_id_t    GNT_DM  = 1'b1;
    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-array signals of the shared memory port.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [3:0]        dm_be;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
    );

    // Requesters plus memory array side.
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Priority decision between fetch and load/store, with a DM-streak
// starvation guard that forces a fetch grant after STREAK_MAX DM grants.
module mem_arb_pick
    import mips_mem_pkg::*;
#(
    parameter int STREAK_MAX = 4
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    sample_i,
    input  logic    if_req_i,
    input  logic    dm_req_i,
    output logic    gnt_valid_o,
    output gnt_id_t gnt_id_o
);

    localparam int SW = $clog2(STREAK_MAX + 1);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;

    always_comb begin
        gnt_valid_o = if_req_i | dm_req_i;
        gnt_id_o    = GNT_IF;
        if (dm_req_i && !(if_req_i && streak_q == SW'(STREAK_MAX))) begin
            gnt_id_o = GNT_DM;
        end

        // Streak only moves on arbitration cycles; a DM grant with fetch waiting counts.
        streak_d = streak_q;
        if (sample_i) begin
            if (!if_req_i || gnt_id_o == GNT_IF) begin
                streak_d = '0;
            end else if (streak_q != SW'(STREAK_MAX)) begin
                streak_d = streak_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store transactions through one fixed-latency
// memory port; one transaction in flight, all outputs registered.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STREAK_MAX = 4
) (
    input logic               CLK,
    input logic               RST,
    mem_port_arbiter_if.slave bus
);

    localparam int CW = $clog2(MEM_LAT + 1);

    arb_state_e        state_q;
    logic [CW-1:0]     lat_q;
    gnt_id_t           owner_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [3:0]        mem_be_q;
    logic              if_ack_q;
    logic              dm_ack_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              busy_q;

    logic              gnt_valid;
    gnt_id_t           gnt_id;

    mem_arb_pick #(
        .STREAK_MAX(STREAK_MAX)
    ) u_pick (
        .clk_i      (CLK),
        .rst_i      (RST),
        .sample_i   (state_q == IDLE),
        .if_req_i   (bus.if_req),
        .dm_req_i   (bus.dm_req),
        .gnt_valid_o(gnt_valid),
        .gnt_id_o   (gnt_id)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            owner_q     <= GNT_IF;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        // Winner's fields go straight into the mem_* output registers.
                        owner_q  <= gnt_id;
                        mem_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ISSUE;
                        if (gnt_id == GNT_DM) begin
                            mem_we_q    <= bus.dm_we;
                            mem_addr_q  <= bus.dm_addr;
                            mem_wdata_q <= bus.dm_wdata;
                            mem_be_q    <= bus.dm_be;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= bus.if_addr;
                            mem_wdata_q <= '0;
                            mem_be_q    <= BE_WORD;
                        end
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    lat_q    <= CW'(MEM_LAT);
                    state_q  <= WAIT;
                end
                WAIT: begin
                    lat_q <= lat_q - CW'(1);
                    if (lat_q == CW'(1)) begin
                        if (owner_q == GNT_DM) begin
                            dm_rdata_q <= bus.mem_rdata;
                            dm_ack_q   <= 1'b1;
                        end else begin
                            if_rdata_q <= bus.mem_rdata;
                            if_ack_q   <= 1'b1;
                        end
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    if_ack_q <= 1'b0;
                    dm_ack_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.busy      = busy_q;

endmodule
